// File: rtl/tb_scoreboard_xperm_rv32.sv
`default_nettype none
// ============================================================================
// tb_scoreboard_xperm_rv32 : in-order expected-vs-actual rd scoreboard (xperm8/4)
// Revision 1.0
// ============================================================================
module tb_scoreboard_xperm_rv32 #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                   g_clk,
  input  logic                   g_resetn,
  input  logic                   issue_valid,
  input  logic [31:0]            issue_expected,
  output logic                   issue_ready,
  input  logic                   rsp_valid,
  input  logic [31:0]            rsp_rd,
  output logic [$clog2(DEPTH):0] outstanding,
  output logic [CNT_W-1:0]       pass_count,
  output logic [CNT_W-1:0]       fail_count,
  output logic                   mismatch,
  output logic [31:0]            first_exp,
  output logic [31:0]            first_act,
  output logic                   first_valid,
  output logic                   err_overflow,
  output logic                   err_underflow
);

  localparam int               c_aw      = $clog2(DEPTH);
  localparam logic [c_aw:0]    c_depth   = (c_aw + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] c_cnt_max = '1;

  logic [31:0]   r_mem [DEPTH];
  logic [c_aw:0] r_wptr;
  logic [c_aw:0] r_rptr;

  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic          w_push;
  logic [31:0]   w_head;
  logic          w_match;

  assign outstanding = r_wptr - r_rptr;
  assign w_full      = (outstanding == c_depth);
  assign w_empty     = (outstanding == '0);
  assign issue_ready = !w_full;

  // A pop frees the slot being written, so a full FIFO can still take a push.
  assign w_pop   = rsp_valid && !w_empty;
  assign w_push  = issue_valid && (!w_full || w_pop);
  assign w_head  = r_mem[r_rptr[c_aw-1:0]];
  assign w_match = (rsp_rd == w_head);

  // Storage needs no reset: entries are only visible between the pointers.
  always_ff @(posedge g_clk) begin
    if (w_push) begin
      r_mem[r_wptr[c_aw-1:0]] <= issue_expected;
    end
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      r_wptr        <= '0;
      r_rptr        <= '0;
      pass_count    <= '0;
      fail_count    <= '0;
      mismatch      <= 1'b0;
      first_exp     <= '0;
      first_act     <= '0;
      first_valid   <= 1'b0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      mismatch <= w_pop && !w_match;

      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end

      if (w_pop && w_match && (pass_count != c_cnt_max)) begin
        pass_count <= pass_count + 1'b1;
      end
      if (w_pop && !w_match && (fail_count != c_cnt_max)) begin
        fail_count <= fail_count + 1'b1;
      end

      // Only the first mismatch is kept; later ones leave the capture alone.
      if (w_pop && !w_match && !first_valid) begin
        first_exp   <= w_head;
        first_act   <= rsp_rd;
        first_valid <= 1'b1;
      end

      if (issue_valid && !w_push) begin
        err_overflow <= 1'b1;
      end
      if (rsp_valid && w_empty) begin
        err_underflow <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tb_scoreboard_xperm_rv32.sv
`default_nettype none
// Directed bench for tb_scoreboard_xperm_rv32: queue model of expected entries,
// compared against a DEPTH=4 instance (CNT_W=16) and a saturating CNT_W=2 twin.
module tb_tb_scoreboard_xperm_rv32;

  localparam int DEPTH = 4;
  localparam int PW    = $clog2(DEPTH) + 1;

  logic          g_clk = 1'b0;
  logic          g_resetn = 1'b0;
  logic          issue_valid = 1'b0;
  logic [31:0]   issue_expected = '0;
  logic          rsp_valid = 1'b0;
  logic [31:0]   rsp_rd = '0;

  logic          issue_ready;
  logic [PW-1:0] outstanding;
  logic [15:0]   pass_count;
  logic [15:0]   fail_count;
  logic          mismatch;
  logic [31:0]   first_exp;
  logic [31:0]   first_act;
  logic          first_valid;
  logic          err_overflow;
  logic          err_underflow;

  logic          s_issue_ready;
  logic [PW-1:0] s_outstanding;
  logic [1:0]    s_pass_count;
  logic [1:0]    s_fail_count;
  logic          s_mismatch;
  logic [31:0]   s_first_exp;
  logic [31:0]   s_first_act;
  logic          s_first_valid;
  logic          s_err_overflow;
  logic          s_err_underflow;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] q[$];
  logic [31:0] m_pass, m_fail, m_fexp, m_fact;
  logic        m_mis, m_fv, m_ovf, m_unf;
  logic [31:0] vals [10];

  always #5 g_clk = ~g_clk;

  tb_scoreboard_xperm_rv32 #(.DEPTH(DEPTH), .CNT_W(16)) dut (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .issue_valid(issue_valid), .issue_expected(issue_expected), .issue_ready(issue_ready),
    .rsp_valid(rsp_valid), .rsp_rd(rsp_rd), .outstanding(outstanding),
    .pass_count(pass_count), .fail_count(fail_count), .mismatch(mismatch),
    .first_exp(first_exp), .first_act(first_act), .first_valid(first_valid),
    .err_overflow(err_overflow), .err_underflow(err_underflow)
  );

  tb_scoreboard_xperm_rv32 #(.DEPTH(DEPTH), .CNT_W(2)) dut_sat (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .issue_valid(issue_valid), .issue_expected(issue_expected), .issue_ready(s_issue_ready),
    .rsp_valid(rsp_valid), .rsp_rd(rsp_rd), .outstanding(s_outstanding),
    .pass_count(s_pass_count), .fail_count(s_fail_count), .mismatch(s_mismatch),
    .first_exp(s_first_exp), .first_act(s_first_act), .first_valid(s_first_valid),
    .err_overflow(s_err_overflow), .err_underflow(s_err_underflow)
  );

  function automatic logic [31:0] xperm8(input logic [31:0] rs1, input logic [31:0] rs2);
    logic [31:0] r;
    logic [7:0]  idx;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      idx = rs2[8*i +: 8];
      if (idx < 8'd4) r[8*i +: 8] = rs1[8*idx[1:0] +: 8];
    end
    return r;
  endfunction

  function automatic logic [31:0] sat3(input logic [31:0] v);
    return (v > 32'd3) ? 32'd3 : v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_pass = '0; m_fail = '0; m_fexp = '0; m_fact = '0;
    m_mis = 1'b0; m_fv = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".outstanding"}, 32'(outstanding), 32'(q.size()));
    check({tag, ".issue_ready"}, 32'(issue_ready), 32'(q.size() != DEPTH));
    check({tag, ".pass_count"}, 32'(pass_count), m_pass);
    check({tag, ".fail_count"}, 32'(fail_count), m_fail);
    check({tag, ".mismatch"}, 32'(mismatch), 32'(m_mis));
    check({tag, ".first_valid"}, 32'(first_valid), 32'(m_fv));
    check({tag, ".first_exp"}, first_exp, m_fexp);
    check({tag, ".first_act"}, first_act, m_fact);
    check({tag, ".err_overflow"}, 32'(err_overflow), 32'(m_ovf));
    check({tag, ".err_underflow"}, 32'(err_underflow), 32'(m_unf));
    check({tag, ".sat_pass"}, 32'(s_pass_count), sat3(m_pass));
    check({tag, ".sat_fail"}, 32'(s_fail_count), sat3(m_fail));
    check({tag, ".sat_outstanding"}, 32'(s_outstanding), 32'(q.size()));
  endtask

  // One clock of stimulus; the model is advanced at the same edge the DUT sees.
  task automatic step(input string tag, input logic iv, input logic [31:0] ie,
                      input logic rv, input logic [31:0] rr);
    logic full, empty, pop, push;
    logic [31:0] head;
    issue_valid = iv; issue_expected = ie; rsp_valid = rv; rsp_rd = rr;
    @(posedge g_clk);
    full  = (q.size() == DEPTH);
    empty = (q.size() == 0);
    pop   = rv && !empty;
    push  = iv && (!full || pop);
    m_mis = 1'b0;
    if (rv && empty) m_unf = 1'b1;
    if (iv && !push) m_ovf = 1'b1;
    if (pop) begin
      head = q.pop_front();
      if (rr === head) m_pass++;
      else begin
        m_fail++;
        m_mis = 1'b1;
        if (!m_fv) begin m_fv = 1'b1; m_fexp = head; m_fact = rr; end
      end
    end
    if (push) q.push_back(ie);
    #1;
    issue_valid = 1'b0; rsp_valid = 1'b0;
    check_all(tag);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge g_clk);
    #1;
    check_all("reset");
    g_resetn = 1'b1;

    // In-order matching responses
    step("m_push0", 1'b1, 32'h03020100, 1'b0, '0);
    step("m_push1", 1'b1, 32'hA5A5A5A5, 1'b0, '0);
    step("m_rsp0", 1'b0, '0, 1'b1, 32'h03020100);
    step("m_rsp1", 1'b0, '0, 1'b1, 32'hA5A5A5A5);
    check("match.pass2", 32'(pass_count), 32'd2);
    check("match.empty", 32'(outstanding), 32'd0);

    // Two mismatches, only the first captured
    step("x_push0", 1'b1, 32'h11223344, 1'b0, '0);
    step("x_push1", 1'b1, 32'h55667788, 1'b0, '0);
    step("x_rsp0", 1'b0, '0, 1'b1, 32'h11223345);
    check("mis.pulse1", 32'(mismatch), 32'd1);
    step("x_rsp1", 1'b0, '0, 1'b1, 32'h00000000);
    check("mis.pulse2", 32'(mismatch), 32'd1);
    step("x_idle", 1'b0, '0, 1'b0, '0);
    check("mis.low", 32'(mismatch), 32'd0);
    check("mis.fail2", 32'(fail_count), 32'd2);
    check("mis.first_exp", first_exp, 32'h11223344);
    check("mis.first_act", first_act, 32'h11223345);
    check("mis.first_valid", 32'(first_valid), 32'd1);

    // Fill, overflow, then push+pop while full
    for (int i = 0; i < DEPTH; i++) step("f_fill", 1'b1, 32'h1000 + 32'(i), 1'b0, '0);
    check("full.not_ready", 32'(issue_ready), 32'd0);
    step("f_ovf", 1'b1, 32'hBAD0BAD0, 1'b0, '0);
    check("full.err_overflow", 32'(err_overflow), 32'd1);
    check("full.outstanding4", 32'(outstanding), 32'd4);
    step("f_pushpop", 1'b1, 32'h2000, 1'b1, 32'h1000);
    check("full.pushpop_outst", 32'(outstanding), 32'd4);
    step("f_drain1", 1'b0, '0, 1'b1, 32'h1001);
    step("f_drain2", 1'b0, '0, 1'b1, 32'h1002);
    step("f_drain3", 1'b0, '0, 1'b1, 32'h1003);
    step("f_drain4", 1'b0, '0, 1'b1, 32'h2000);
    check("full.pass7", 32'(pass_count), 32'd7);

    // Wrap-around with pipelined push/pop of xperm8 results
    for (int i = 0; i < 10; i++) begin
      vals[i] = xperm8($urandom(), {8'($urandom_range(0, 5)), 8'($urandom_range(0, 5)),
                                    8'($urandom_range(0, 5)), 8'($urandom_range(0, 5))});
    end
    step("w_first", 1'b1, vals[0], 1'b0, '0);
    for (int i = 1; i < 10; i++) step("w_pair", 1'b1, vals[i], 1'b1, vals[i-1]);
    step("w_last", 1'b0, '0, 1'b1, vals[9]);
    check("wrap.pass17", 32'(pass_count), 32'd17);
    check("wrap.fail2", 32'(fail_count), 32'd2);

    // Asynchronous reset with 3 entries outstanding
    step("r_push0", 1'b1, 32'h0A0A0A0A, 1'b0, '0);
    step("r_push1", 1'b1, 32'h0B0B0B0B, 1'b0, '0);
    step("r_push2", 1'b1, 32'h0C0C0C0C, 1'b0, '0);
    #2;
    g_resetn = 1'b0;
    rsp_valid = 1'b1;
    rsp_rd = 32'h0A0A0A0A;
    #1;
    model_reset();
    check_all("rst_async");
    check("rst.ready", 32'(issue_ready), 32'd1);
    @(posedge g_clk);
    #1;
    check_all("rst_held");
    rsp_valid = 1'b0;
    g_resetn = 1'b1;

    // Underflow with simultaneous push
    step("u_both", 1'b1, 32'hDEADBEEF, 1'b1, 32'h00000000);
    check("unf.flag", 32'(err_underflow), 32'd1);
    check("unf.outstanding1", 32'(outstanding), 32'd1);
    check("unf.pass0", 32'(pass_count), 32'd0);
    step("u_rsp", 1'b0, '0, 1'b1, 32'hDEADBEEF);
    check("unf.pass1", 32'(pass_count), 32'd1);

    // Saturation of the 2-bit counters
    for (int i = 0; i < 5; i++) begin
      step("s_push", 1'b1, 32'h5A000000 + 32'(i), 1'b0, '0);
      step("s_rsp", 1'b0, '0, 1'b1, 32'h5A000000 + 32'(i));
    end
    check("sat.pass3", 32'(s_pass_count), 32'd3);
    check("sat.wide_pass6", 32'(pass_count), 32'd6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tb_scoreboard_xperm_rv32.md
Name: tb_scoreboard_xperm_rv32

Overview:
- In-order scoreboard that sits directly downstream of the xperm8/xperm4 rv32 reference checkers in the crypto-FU bench.
- At issue, it captures the checker's expected rd into a FIFO.
- It pops one entry per DUT response, compares it with the DUT rd, and keeps pass/fail counters, first-mismatch capture and sticky protocol-error flags.
- It is synthesisable, so it can also run in FPGA self-test builds.

Parameters:
- DEPTH, 4: expected-result FIFO entries. Must be a power of two, ≥2.
- CNT_W, 16: width of the pass and fail counters.

Ports:
- g_clk  in  1  Clock. All state updates on the rising edge.
- g_resetn  in  1  Asynchronous active-low reset.
- issue_valid  in  1  Instruction issued to DUT; issue_expected is valid.
- issue_expected  in  32  Checker rd for the issued operands.
- issue_ready  out  1  FIFO not full.
- rsp_valid  in  1  DUT result valid this cycle.
- rsp_rd  in  32  DUT result.
- outstanding  out  $clog2(DEPTH)+1  Entries currently in the FIFO.
- pass_count  out  CNT_W  Matching responses.
- fail_count  out  CNT_W  Mismatching responses.
- mismatch  out  1  One-cycle pulse, one cycle after a mismatching response.
- first_exp  out  32  Expected value of the first mismatch.
- first_act  out  32  Actual value of the first mismatch.
- first_valid  out  1  first_exp/first_act hold a capture.
- err_overflow  out  1  Sticky: push attempted when the FIFO could not accept it.
- err_underflow  out  1  Sticky: response arrived with the FIFO empty.

Behaviour:
- Reset (g_resetn low, asynchronous):
  - Pointers and outstanding go to 0.
  - All counters, flags, mismatch and first_* go to 0.
  - issue_ready=1 while in reset.
  - Reset mid-operation discards all entries; no compare happens for the response in that cycle.
- FIFO:
  - Read/write pointers are $clog2(DEPTH)+1 bits wide; wrap is natural modulo.
  - full = (outstanding==DEPTH); empty = (outstanding==0).
  - issue_ready = !full (combinational from registered state).
- Push: occurs on issue_valid && (!full || pop).
  - A push when full with a simultaneous pop is accepted; outstanding is unchanged.
  - issue_valid && full && !rsp_valid drops the data and sets err_overflow.
- Pop: occurs on rsp_valid && !empty.
  - Compare (rsp_rd == head entry) in the same cycle; results are registered.
  - Match: pass_count+1. Mismatch: fail_count+1 and mismatch=1 on the next cycle.
  - If first_valid==0 on a mismatch: capture head into first_exp and rsp_rd into first_act, and set first_valid. Later mismatches do not overwrite the capture.
- No bypass: rsp_valid while empty is an underflow, even if issue_valid is high in the same cycle.
  - The underflow sets err_underflow; no counter changes.
  - The simultaneous push is still accepted.
- Counters saturate at 2^CNT_W-1 and never wrap.
- Latency:
  - Issue to entry visible at head: 1 cycle. A response in the cycle after issue compares against it.
  - Response to counter/mismatch update: 1 cycle.
- Sticky flags and first_* clear only on reset.
- mismatch is low in every cycle not immediately following a mismatching pop.

Test Plan:
- In-order match:
  - Stimulus: push 0x03020100, then 0xA5A5A5A5; respond with the same values on cycles 3 and 4.
  - Required response: pass_count=2, fail_count=0, mismatch never high, outstanding returns to 0.
- First-mismatch capture:
  - Stimulus: push 0x11223344, 0x55667788; respond 0x11223345, then 0x00000000.
  - Required response: fail_count=2, mismatch pulses twice, first_exp=0x11223344, first_act=0x11223345, first_valid=1.
- Full/overflow:
  - Stimulus: push 4 entries with DEPTH=4, so issue_ready=0; push again without a response.
  - Required response: err_overflow=1, outstanding=4.
  - Then push and respond in the same cycle: push accepted, outstanding stays 4, no new error.
- Underflow:
  - Stimulus: rsp_valid with the FIFO empty, together with issue_valid (issue_expected=0xDEADBEEF).
  - Required response: err_underflow=1, counters unchanged, outstanding=1.
  - A following response of 0xDEADBEEF gives pass_count=1.
- Wrap-around:
  - Stimulus: 10 push/pop pairs of random xperm8 results with DEPTH=4.
  - Required response: pass_count=10, pointers wrap without loss.
- Reset mid-operation and saturation:
  - Stimulus: assert g_resetn low asynchronously with 3 entries outstanding.
  - Required response: all outputs go to 0 immediately and issue_ready=1.
  - Saturation: with CNT_W=2, issue 5 matching pairs; pass_count holds at 3.
